piso_bit_serializer: RTL and testbench

//   Parallel-in/serial-out stage that feeds the one-bit stream x of the odd/even ones-zeros tracker FSM.

---
 rtl/piso_bit_serializer_if.sv | 24 ++
 rtl/piso_bit_serializer.sv | 133 +++++++++++++
 tb/tb_piso_bit_serializer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/piso_bit_serializer_if.sv
// Word-in / bit-out handshake bundle for piso_bit_serializer.
// The master side offers words; the slave side (the serializer) returns the bit stream.
interface piso_bit_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             x;
   logic             x_valid;
   logic             frame_start;
   logic             frame_end;
   logic             busy;

   modport master (
      output din, din_valid,
      input  din_ready, x, x_valid, frame_start, frame_end, busy
   );

   modport slave (
      input  din, din_valid,
      output din_ready, x, x_valid, frame_start, frame_end, busy
   );
endinterface

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: one WIDTH-bit word in, one bit per clk out, framed by start/end strobes.
// Define PARITY_BIT_EN to append an even-parity bit (PAR state) after each word's data bits.
module piso_bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   piso_bit_serializer_if.slave  bus
);
   localparam int             CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`ifndef PARITY_BIT_EN
   localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(WIDTH - 2);
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
`ifdef PARITY_BIT_EN
      , PAR = 2'd2
`endif
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] shreg_r;
   logic [CNT_W-1:0] cnt_r;
   logic             par_r;
   logic             x_r;
   logic             x_valid_r;
   logic             frame_start_r;
   logic             frame_end_r;
   logic             ready_s;
   logic             accept_s;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   function automatic logic even_parity(input logic [WIDTH-1:0] w);
      return ^w;
   endfunction

   // Ready in IDLE and in the cycle that carries the frame's final bit
   always_comb begin
      ready_s = 1'b0;
      case (state_r)
         IDLE:    ready_s = 1'b1;
`ifdef PARITY_BIT_EN
         SHIFT:   ready_s = 1'b0;
         PAR:     ready_s = 1'b1;
`else
         SHIFT:   ready_s = (cnt_r == LAST);
`endif
         default: ready_s = 1'b0;
      endcase
   end

   assign accept_s         = bus.din_valid & ready_s;
   assign bus.din_ready    = ready_s;
   assign bus.busy         = (state_r != IDLE);
   assign bus.x            = x_r;
   assign bus.x_valid      = x_valid_r;
   assign bus.frame_start  = frame_start_r;
   assign bus.frame_end    = frame_end_r;

   // Frame sequencer; the shift register holds the bits not yet presented on x
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= IDLE;
         shreg_r       <= '0;
         cnt_r         <= '0;
         par_r         <= 1'b0;
         x_r           <= 1'b0;
         x_valid_r     <= 1'b0;
         frame_start_r <= 1'b0;
         frame_end_r   <= 1'b0;
      end else if (accept_s) begin
         state_r       <= SHIFT;
         shreg_r       <= shift_word(bus.din);
         cnt_r         <= '0;
         par_r         <= even_parity(bus.din);
         x_r           <= first_bit(bus.din);
         x_valid_r     <= 1'b1;
         frame_start_r <= 1'b1;
         frame_end_r   <= 1'b0;
      end else begin
         case (state_r)
            SHIFT: begin
               if (cnt_r != LAST) begin
                  cnt_r         <= cnt_r + 1'b1;
                  shreg_r       <= shift_word(shreg_r);
                  x_r           <= first_bit(shreg_r);
                  x_valid_r     <= 1'b1;
                  frame_start_r <= 1'b0;
`ifdef PARITY_BIT_EN
                  frame_end_r   <= 1'b0;
`else
                  frame_end_r   <= (cnt_r == LAST_M1);
`endif
               end else begin
`ifdef PARITY_BIT_EN
                  state_r       <= PAR;
                  x_r           <= par_r;
                  x_valid_r     <= 1'b1;
                  frame_start_r <= 1'b0;
                  frame_end_r   <= 1'b1;
`else
                  state_r       <= IDLE;
                  cnt_r         <= '0;
                  x_r           <= 1'b0;
                  x_valid_r     <= 1'b0;
                  frame_start_r <= 1'b0;
                  frame_end_r   <= 1'b0;
`endif
               end
            end
            default: begin
               state_r       <= IDLE;
               cnt_r         <= '0;
               x_r           <= 1'b0;
               x_valid_r     <= 1'b0;
               frame_start_r <= 1'b0;
               frame_end_r   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_piso_bit_serializer.sv
// Scoreboard bench: drivers push expected {x, frame_start, frame_end} per accepted word,
// monitors pop and compare on every x_valid cycle. Honors PARITY_BIT_EN like the design.
module tb_piso_bit_serializer;
   localparam int W = 8;
`ifdef PARITY_BIT_EN
   localparam int FLEN = W + 1;
`else
   localparam int FLEN = W;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   run_len = 0;
   int   max_run = 0;
   logic [2:0] qm[$];
   logic [2:0] ql[$];
   logic [2:0] em;
   logic [2:0] el;

   always #5 clk = ~clk;

   piso_bit_serializer_if #(.WIDTH(W)) bm ();
   piso_bit_serializer_if #(.WIDTH(W)) bl ();

   piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(bm));
   piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(bl));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected stream for one word: data bits in wire order, then optional parity
   task automatic push_word(input logic [W-1:0] w, input bit msb, input bit to_l);
      logic [2:0] e;
      for (int i = 0; i < W; i++) begin
         e[2] = msb ? w[W-1-i] : w[i];
         e[1] = (i == 0);
         e[0] = (i == W - 1) && (FLEN == W);
         if (to_l) ql.push_back(e); else qm.push_back(e);
      end
`ifdef PARITY_BIT_EN
      e = {^w, 1'b0, 1'b1};
      if (to_l) ql.push_back(e); else qm.push_back(e);
`endif
   endtask

   task automatic send_m(input logic [W-1:0] w);
      int n = 0;
      bm.din = w;
      bm.din_valid = 1'b1;
      while (!bm.din_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("m_accept_timeout", {31'd0, bm.din_ready}, 32'd1);
      push_word(w, 1'b1, 1'b0);
      @(posedge clk); #1;
      bm.din_valid = 1'b0;
   endtask

   task automatic send_l(input logic [W-1:0] w);
      int n = 0;
      bl.din = w;
      bl.din_valid = 1'b1;
      while (!bl.din_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("l_accept_timeout", {31'd0, bl.din_ready}, 32'd1);
      push_word(w, 1'b0, 1'b1);
      @(posedge clk); #1;
      bl.din_valid = 1'b0;
   endtask

   task automatic wait_idle();
      repeat (FLEN + 4) @(posedge clk);
      #1;
   endtask

   // Monitor for the MSB-first instance
   always @(negedge clk) begin
      if (!reset && bm.x_valid) begin
         if (qm.size() == 0) begin
            checks++; errors++;
            $display("FAIL m_unexpected actual=x_valid expected=idle at %0t", $time);
         end else begin
            em = qm.pop_front();
            chk("m_bit_fs_fe", {29'd0, bm.x, bm.frame_start, bm.frame_end}, {29'd0, em});
         end
      end
   end

   // Monitor for the LSB-first instance
   always @(negedge clk) begin
      if (!reset && bl.x_valid) begin
         if (ql.size() == 0) begin
            checks++; errors++;
            $display("FAIL l_unexpected actual=x_valid expected=idle at %0t", $time);
         end else begin
            el = ql.pop_front();
            chk("l_bit_fs_fe", {29'd0, bl.x, bl.frame_start, bl.frame_end}, {29'd0, el});
         end
      end
   end

   // Longest unbroken x_valid run with busy high on the MSB instance
   always @(negedge clk) begin
      if (reset || !bm.x_valid || !bm.busy) run_len = 0;
      else begin
         run_len++;
         if (run_len > max_run) max_run = run_len;
      end
   end

   initial begin
      bm.din = '0; bm.din_valid = 1'b0;
      bl.din = '0; bl.din_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("reset_outputs", {27'd0, bm.x, bm.x_valid, bm.frame_start, bm.frame_end, bm.busy}, 32'd0);
      chk("reset_ready", {31'd0, bm.din_ready}, 32'd1);

      // MSB-first A5
      send_m(8'hA5);
      wait_idle();

      // LSB-first 01 with din_ready profile across the frame
      send_l(8'h01);
      for (int i = 1; i <= FLEN; i++) begin
         chk("l_ready_profile", {31'd0, bl.din_ready}, {31'd0, (i == FLEN)});
         @(posedge clk); #1;
      end
      wait_idle();

      // Back-to-back FF then 00
      max_run = 0;
      send_m(8'hFF);
      send_m(8'h00);
      wait_idle();
      chk("b2b_run_len", max_run, 2 * FLEN);

      // 3C offered mid-frame must wait for the frame_end cycle
      send_m(8'hA5);
      repeat (2) @(posedge clk);
      #1;
      bm.din = 8'h3C; bm.din_valid = 1'b1;
      @(posedge clk); #1;
      bm.din_valid = 1'b0;
      @(posedge clk); #1;
      send_m(8'h3C);
      wait_idle();

      // Reset mid-frame aborts immediately
      send_m(8'h5A);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("midreset_outputs", {27'd0, bm.x, bm.x_valid, bm.frame_start, bm.frame_end, bm.busy}, 32'd0);
      qm.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("post_reset_valid", {31'd0, bm.x_valid}, 32'd0);
      send_m(8'hC3);
      wait_idle();

      // Parity-sensitive words
      send_m(8'h07);
      send_m(8'h03);
      wait_idle();

      chk("m_queue_drained", qm.size(), 32'd0);
      chk("l_queue_drained", ql.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
